// File: rtl/snap_capture_sequencer_pkg.sv
// Shared definitions for the snapshot capture sequencer: FSM states and
// bit positions inside the software control and status words.
package snap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } snap_state_e;

    localparam int CTRL_ARM      = 0;
    localparam int CTRL_TRIG_SEL = 1;
    localparam int CTRL_WE_SEL   = 2;
    localparam int CTRL_CIRC     = 3;

    localparam int ST_DONE = 31;
    localparam int ST_BUSY = 30;

endpackage

// File: rtl/snap_capture_sequencer_if.sv
// Control/sample inputs, BRAM write port and status word of the capture
// sequencer; the sequencer is the slave, software/sample source the master.
interface snap_capture_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [31:0]       ctrl_word;
    logic [DATA_W-1:0] din;
    logic              trig;
    logic              we_in;
    logic              stop;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;
    logic              bram_we;
    logic [31:0]       status_word;

    modport master (
        output ctrl_word, din, trig, we_in, stop,
        input  bram_addr, bram_data, bram_we, status_word
    );

    modport slave (
        input  ctrl_word, din, trig, we_in, stop,
        output bram_addr, bram_data, bram_we, status_word
    );
endinterface

// File: rtl/snap_capture_sequencer.sv
// Sequences one snapshot capture into a BRAM: arm/trigger/write-enable decode,
// registered BRAM write port, and a done/busy/count status word.
module snap_capture_sequencer
    import snap_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                     user_clk,
    input  logic                     user_rst_n,
    snap_capture_sequencer_if.slave  bus
);

    localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;
    localparam logic [ADDR_W:0]   COUNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    snap_state_e       state_q, state_d;
    logic              arm_q;
    logic              trig_sel_q, trig_sel_d;
    logic              we_sel_q, we_sel_d;
    logic              circ_q, circ_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              bram_we_q, bram_we_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0] bram_data_q, bram_data_d;

    logic arm_edge;
    logic go;
    logic valid;
    logic capture_en;

    assign arm_edge = bus.ctrl_word[CTRL_ARM] & ~arm_q;
    assign go       = ~trig_sel_q | bus.trig;
    assign valid    = ~we_sel_q | bus.we_in;

    logic unused_ctrl_bits;
    assign unused_ctrl_bits = ^bus.ctrl_word[31:4];

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q     <= IDLE;
            arm_q       <= 1'b0;
            trig_sel_q  <= 1'b0;
            we_sel_q    <= 1'b0;
            circ_q      <= 1'b0;
            addr_cnt_q  <= '0;
            count_q     <= '0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_data_q <= '0;
        end else begin
            state_q     <= state_d;
            arm_q       <= bus.ctrl_word[CTRL_ARM];
            trig_sel_q  <= trig_sel_d;
            we_sel_q    <= we_sel_d;
            circ_q      <= circ_d;
            addr_cnt_q  <= addr_cnt_d;
            count_q     <= count_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_data_q <= bram_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        trig_sel_d  = trig_sel_q;
        we_sel_d    = we_sel_q;
        circ_d      = circ_q;
        addr_cnt_d  = addr_cnt_q;
        count_d     = count_q;
        bram_we_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        bram_data_d = bram_data_q;
        capture_en  = 1'b0;

        // An arm edge wins over everything: restart from any state, no write.
        if (arm_edge) begin
            state_d    = ARMED;
            trig_sel_d = bus.ctrl_word[CTRL_TRIG_SEL];
            we_sel_d   = bus.ctrl_word[CTRL_WE_SEL];
            circ_d     = bus.ctrl_word[CTRL_CIRC];
            addr_cnt_d = '0;
            count_d    = '0;
        end else begin
            case (state_q)
                IDLE: ;
                ARMED: begin
                    if (go) begin
                        state_d    = CAPTURE;
                        capture_en = 1'b1;
                    end
                end
                CAPTURE: begin
                    capture_en = 1'b1;
                    if (circ_q && bus.stop) state_d = DONE;
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end

        if (capture_en && valid) begin
            bram_we_d   = 1'b1;
            bram_addr_d = addr_cnt_q;
            bram_data_d = bus.din;
            addr_cnt_d  = addr_cnt_q + 1'b1;
            if (!(circ_q && count_q == COUNT_FULL)) count_d = count_q + 1'b1;
            if (!circ_q && addr_cnt_q == ADDR_LAST) state_d = DONE;
        end
    end

    assign bus.bram_we   = bram_we_q;
    assign bus.bram_addr = bram_addr_q;
    assign bus.bram_data = bram_data_q;

    // Count low bits equal the write pointer until the count saturates at a
    // power of two, so OR-ing in the pointer exposes the circular head.
    always_comb begin
        bus.status_word           = '0;
        bus.status_word[ST_DONE]  = (state_q == DONE);
        bus.status_word[ST_BUSY]  = (state_q == ARMED) || (state_q == CAPTURE);
        bus.status_word[ADDR_W:0] = count_q | {1'b0, addr_cnt_q};
    end

endmodule
